// File: rtl/accum_pkg.sv
// Shared types and widths for the accumulate-and-emit sample stage.
// No logic; constants only.
// No flow control here; consumers own their handshakes.
package accum_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 12;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/accum_if.sv
// Sample input handshake plus registered frame-result bus of the accumulate stage.
// Wires only, zero latency.
// in_ready is driven by the stage; the sample source holds off while it is low.
interface accum_if;
    import accum_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] pin;
    logic              in_ready;
    logic [ACC_W-1:0]  out;
    logic              out_ld;
    logic              ovf;

    // Sample source / result consumer side
    modport master (
        output in_valid, pin,
        input  in_ready, out, out_ld, ovf
    );

    // Accumulate stage side
    modport slave (
        input  in_valid, pin,
        output in_ready, out, out_ld, ovf
    );

endinterface

// File: rtl/accum_sample_counter.sv
// Counts accepted samples in a frame and flags the last one (count == N_SAMPLES-1).
// Count updates one cycle after clr/en; term_o is combinational from the count.
// No backpressure; en_i is expected to be the accepted-beat strobe.
module sample_counter
    import accum_pkg::*;
#(
    parameter int N_SAMPLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment so a new frame always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == CNT_W'(N_SAMPLES - 1));

endmodule

// File: rtl/accum_stage.sv
// Sums N_SAMPLES unsigned 8-bit samples per frame and emits a 12-bit sum with ovf; build option ACCUM_SAT_EN saturates instead of wrapping.
// out/out_ld/ovf are valid in the cycle after the last accepted beat (one-cycle EMIT).
// in_ready is high only in ACCUM; samples offered in IDLE or EMIT are ignored, no queuing.
module accum_stage
    import accum_pkg::*;
#(
    parameter int N_SAMPLES = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    output logic   busy,
    accum_if.slave bus
);

    state_t           state_q;
    state_t           state_d;

    logic             in_ready;
    logic             beat;
    logic             last_beat;
    logic             frame_clr;
    logic             term;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_flag_q;
    logic             ovf_flag_d;

    logic [ACC_W-1:0] out_q;
    logic             ovf_q;
    logic             out_ld_q;
    logic             busy_q;

    sample_counter #(
        .N_SAMPLES (N_SAMPLES)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_clr),
        .en_i   (beat),
        .term_o (term)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only counts in IDLE, EMIT always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = ACCUM;
            ACCUM:   if (last_beat) state_d = EMIT;
            EMIT:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and frame control strobes
    always_comb begin
        in_ready  = (state_q == ACCUM);
        beat      = bus.in_valid & in_ready;
        last_beat = beat & term;
        frame_clr = (state_q == IDLE) & start;
    end

    // Next accumulator value; the 13th sum bit is the carry that marks an overflowed frame
    always_comb begin
        sum        = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.pin};
        acc_d      = acc_q;
        ovf_flag_d = ovf_flag_q;
        if (frame_clr) begin
            acc_d      = '0;
            ovf_flag_d = 1'b0;
        end else if (beat) begin
            ovf_flag_d = ovf_flag_q | sum[ACC_W];
`ifdef ACCUM_SAT_EN
            // Once the frame has overflowed it pins at full scale until EMIT
            acc_d      = ovf_flag_d ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d      = sum[ACC_W-1:0];
`endif
        end
    end

    // Datapath and registered outputs; the result is captured on the last beat so it appears in EMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            ovf_flag_q <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
            out_ld_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ovf_flag_q <= ovf_flag_d;
            out_ld_q   <= last_beat;
            busy_q     <= (state_d != IDLE);
            if (last_beat) begin
                out_q <= acc_d;
                ovf_q <= ovf_flag_d;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out      = out_q;
    assign bus.ovf      = ovf_q;
    assign bus.out_ld   = out_ld_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_accum_stage.sv
// Directed bench for accum_stage: four instances (N_SAMPLES 16, 17, 4, 1) share clock, reset and sample bus.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Each instance has its own start; idle instances ignore the shared in_valid.
module tb_accum_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] pin = 8'h00;
    logic       st16 = 1'b0, st17 = 1'b0, st4 = 1'b0, st1 = 1'b0;
    logic       bz16, bz17, bz4, bz1;

    int n_checks = 0;
    int n_fail   = 0;
    int ld16 = 0, ld17 = 0, ld4 = 0, ld1 = 0;

`ifdef ACCUM_SAT_EN
    localparam logic [11:0] EXP17 = 12'hFFF;
`else
    localparam logic [11:0] EXP17 = 12'h0EF;
`endif

    always #5 clk = ~clk;

    accum_if b16 ();
    accum_if b17 ();
    accum_if b4 ();
    accum_if b1 ();

    assign b16.in_valid = vld;
    assign b16.pin      = pin;
    assign b17.in_valid = vld;
    assign b17.pin      = pin;
    assign b4.in_valid  = vld;
    assign b4.pin       = pin;
    assign b1.in_valid  = vld;
    assign b1.pin       = pin;

    accum_stage #(.N_SAMPLES(16)) u_dut16 (.clk(clk), .rst(rst), .start(st16), .busy(bz16), .bus(b16));
    accum_stage #(.N_SAMPLES(17)) u_dut17 (.clk(clk), .rst(rst), .start(st17), .busy(bz17), .bus(b17));
    accum_stage #(.N_SAMPLES(4))  u_dut4  (.clk(clk), .rst(rst), .start(st4),  .busy(bz4),  .bus(b4));
    accum_stage #(.N_SAMPLES(1))  u_dut1  (.clk(clk), .rst(rst), .start(st1),  .busy(bz1),  .bus(b1));

    // Count load strobes per instance, sampled mid-cycle
    always @(negedge clk) begin
        ld16 += int'(b16.out_ld);
        ld17 += int'(b17.out_ld);
        ld4  += int'(b4.out_ld);
        ld1  += int'(b1.out_ld);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        vld = v;
        pin = d;
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        vld = 1'b1;
        pin = 8'hAA;
        st16 = 1'b1;
        tick();
        tick();
        check("rst_out",      32'(b16.out),      32'h0);
        check("rst_out_ld",   32'(b16.out_ld),   32'h0);
        check("rst_busy",     32'(bz16),         32'h0);
        check("rst_in_ready", 32'(b16.in_ready), 32'h0);
        check("rst_ovf",      32'(b16.ovf),      32'h0);
        rst  = 1'b0;
        st16 = 1'b0;
        send(1'b0, 8'h00);

        // 16 x 0xFF with N=16: 0xFF0, no overflow
        st16 = 1'b1;
        tick();
        st16 = 1'b0;
        check("f16_in_ready", 32'(b16.in_ready), 32'h1);
        check("f16_busy",     32'(bz16),         32'h1);
        for (int i = 0; i < 15; i++) send(1'b1, 8'hFF);
        check("f16_no_early_ld", 32'(b16.out_ld), 32'h0);
        send(1'b1, 8'hFF);
        check("f16_out_ld",  32'(b16.out_ld),   32'h1);
        check("f16_out",     32'(b16.out),      32'hFF0);
        check("f16_ovf",     32'(b16.ovf),      32'h0);
        check("f16_emit_rdy", 32'(b16.in_ready), 32'h0);
        check("f16_emit_busy", 32'(bz16),       32'h1);
        send(1'b0, 8'h00);
        check("f16_ld_low",  32'(b16.out_ld),   32'h0);
        check("f16_idle",    32'(bz16),         32'h0);
        check("f16_hold",    32'(b16.out),      32'hFF0);
        check("f16_ld_count", 32'(ld16),        32'd1);

        // 17 x 0xFF with N=17: overflow, wrap or saturate
        st17 = 1'b1;
        tick();
        st17 = 1'b0;
        for (int i = 0; i < 17; i++) send(1'b1, 8'hFF);
        check("f17_out_ld", 32'(b17.out_ld), 32'h1);
        check("f17_out",    32'(b17.out),    32'(EXP17));
        check("f17_ovf",    32'(b17.ovf),    32'h1);
        send(1'b0, 8'h00);

        // 1,2,3,4 with gaps (N=4); garbage on pin during gaps must not be summed
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 8'(i));
            if (i < 4) begin
                send(1'b0, 8'h63);
                check($sformatf("gap%0d_busy", i), 32'(bz4),       32'h1);
                check($sformatf("gap%0d_ld", i),   32'(b4.out_ld), 32'h0);
            end
        end
        check("f4_out_ld", 32'(b4.out_ld), 32'h1);
        check("f4_out",    32'(b4.out),    32'd10);
        check("f4_ovf",    32'(b4.ovf),    32'h0);
        send(1'b0, 8'h00);

        // Abort after 5 of 16 beats, then a clean frame of 16 ones
        st16 = 1'b1;
        tick();
        st16 = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 8'h01);
        vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bz16),    32'h0);
        check("abort_out",  32'(b16.out), 32'h0);
        tick();
        st16 = 1'b1;
        tick();
        st16 = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1, 8'h01);
        check("f16b_out_ld", 32'(b16.out_ld), 32'h1);
        check("f16b_out",    32'(b16.out),    32'd16);
        send(1'b0, 8'h00);
        check("f16b_ld_count", 32'(ld16), 32'd2);

        // in_valid in IDLE ignored; start held through ACCUM and EMIT ignored
        send(1'b1, 8'd50);
        check("idle_in_ready", 32'(b4.in_ready), 32'h0);
        check("idle_busy",     32'(bz4),         32'h0);
        st4 = 1'b1;
        tick();
        for (int i = 5; i <= 8; i++) send(1'b1, 8'(i));
        check("restart_out_ld", 32'(b4.out_ld), 32'h1);
        check("restart_out",    32'(b4.out),    32'd26);
        send(1'b1, 8'd50);
        check("after_emit_busy", 32'(bz4), 32'h0);
        st4 = 1'b0;
        send(1'b1, 8'd50);
        check("no_queued_start", 32'(bz4),  32'h0);
        check("idle_hold_out",   32'(b4.out), 32'd26);
        st4 = 1'b1;
        vld = 1'b0;
        tick();
        st4 = 1'b0;
        for (int i = 1; i <= 4; i++) send(1'b1, 8'(10 * i));
        check("next_out", 32'(b4.out), 32'd100);
        send(1'b0, 8'h00);
        check("f4_ld_count", 32'(ld4), 32'd3);

        // N=1: a single beat goes straight to EMIT
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        send(1'b1, 8'd200);
        check("n1_out_ld", 32'(b1.out_ld), 32'h1);
        check("n1_out",    32'(b1.out),    32'd200);
        check("n1_ovf",    32'(b1.ovf),    32'h0);
        send(1'b0, 8'h00);
        check("n1_idle",     32'(bz1),  32'h0);
        check("n1_ld_count", 32'(ld1),  32'd1);
        check("f17_ld_count", 32'(ld17), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
REQ-001 Parameter N_SAMPLES, default 16, number of 8-bit samples summed per frame (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 start  input  1  frame start request, honoured only in IDLE.
REQ-005 in_valid  input  1  pin carries a sample this cycle.
REQ-006 pin  input  8  unsigned sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out  output  12  registered frame sum, feeds the downstream 12-bit register pin.
REQ-009 out_ld  output  1  one-cycle load strobe for the downstream 12-bit register ld.
REQ-010 busy  output  1  high in ACCUM and EMIT.
REQ-011 ovf  output  1  frame sum exceeded 4095; valid with out_ld.

Function
REQ-012 FSM states: IDLE, ACCUM, EMIT.
REQ-013 IDLE: start=1 -> ACCUM; acc cleared to 0, sample count cleared to 0, ovf flag cleared.
REQ-014 ACCUM: in_ready=1 combinationally; beat = in_valid & in_ready.
REQ-015 Each beat: acc <= acc + zero-extended pin (13-bit internal add); count += 1.
REQ-016 Beat with count == N_SAMPLES-1 -> EMIT next cycle; no-beat cycles hold acc and count.
REQ-017 EMIT (exactly one cycle): out <= final acc, ovf <= frame overflow flag, out_ld = 1; then -> IDLE.
REQ-018 Latency: out and out_ld asserted together in the cycle after the last accepted beat.
REQ-019 out holds its value until the next EMIT; out_ld is low outside EMIT.
REQ-020 in_ready = 0 in IDLE and EMIT; in_valid there is ignored and pin is not summed.
REQ-021 start outside IDLE is ignored; start in the EMIT cycle is not queued.
REQ-022 N_SAMPLES = 1: a single beat moves ACCUM -> EMIT.
REQ-023 Overflow: 13-bit add carry sets a sticky frame flag; subsequent handling per REQ-027/REQ-028.

Reset
REQ-024 rst=1 at a clock edge: state -> IDLE; acc, count, out, ovf -> 0; out_ld, busy, in_ready -> 0.
REQ-025 rst has priority over start, in_valid and every FSM transition.
REQ-026 rst mid-frame discards the partial sum; no out_ld is issued for that frame.

Configuration
REQ-027 Macro ACCUM_SAT_EN defined: on overflow acc saturates to 12'hFFF and stays there for the rest of the frame; ovf = 1 at EMIT.
REQ-028 ACCUM_SAT_EN undefined: acc wraps modulo 4096; ovf still reports that any wrap occurred.

Structure
REQ-029 Shared package accum_pkg holds DATA_W=8, ACC_W=12, and the state enum (IDLE, ACCUM, EMIT).
REQ-030 Single sub-module sample_counter: 8-bit count with clear, enable, and a terminal flag at N_SAMPLES-1.
REQ-031 All outputs except in_ready are registered.

Verification
REQ-032 Frame of 16 samples of 8'hFF, N_SAMPLES=16 -> out=12'hFF0, ovf=0, one out_ld pulse one cycle after the 16th beat.
REQ-033 N_SAMPLES=17, samples 8'hFF -> ACCUM_SAT_EN: out=12'hFFF, ovf=1; without the macro: out=12'h0EF, ovf=1.
REQ-034 Samples 1,2,3,4 with in_valid gaps between them, N_SAMPLES=4 -> out=10; gap cycles hold acc; busy stays high throughout.
REQ-035 rst asserted after 5 of 16 beats, then new frame of 16 ones -> out=16, no out_ld for the aborted frame.
REQ-036 start pulsed during ACCUM and EMIT, in_valid in IDLE -> no effect; in_ready=0 in IDLE; next frame sums correctly.
